// File: rtl/arith_pkg.sv
// Shared definitions for the sequential arithmetic units.
// State codes and counter sizing used by seq_mult and the divider.
package arith_pkg;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_OP   = 2'b01;
   localparam logic [1:0] ST_DONE = 2'b10;

   // Counter must hold the value w, so 2**cbit > w.
   function automatic int cbit_of(input int w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/seq_mult.sv
// Shift-and-add unsigned multiplier, one multiplier bit per clock.
// start/ready/done_tick handshake shared with the restoring divider.
module seq_mult
   import arith_pkg::*;
#(
   parameter int W    = 8,
   parameter int CBIT = cbit_of(W)
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           start,
   input  logic [W-1:0]   mcnd,
   input  logic [W-1:0]   mplr,
   output logic           ready,
   output logic           done_tick,
   output logic [2*W-1:0] prod
);

   logic [1:0]      state_reg, state_next;
   logic [W-1:0]    a_reg, a_next;
   logic [W-1:0]    ph_reg, ph_next;
   logic [W-1:0]    pl_reg, pl_next;
   logic [CBIT-1:0] n_reg, n_next;
   logic [W:0]      sum;

   always_ff @(posedge clk) begin
      if (!reset_n)
         state_reg <= ST_IDLE;
      else
         state_reg <= state_next;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         a_reg  <= '0;
         ph_reg <= '0;
         pl_reg <= '0;
         n_reg  <= '0;
      end else begin
         a_reg  <= a_next;
         ph_reg <= ph_next;
         pl_reg <= pl_next;
         n_reg  <= n_next;
      end
   end

   // Add-and-shift step; sum keeps the carry as bit W.
   always_comb begin
      sum     = {1'b0, ph_reg};
      a_next  = a_reg;
      ph_next = ph_reg;
      pl_next = pl_reg;
      n_next  = n_reg;
      if (pl_reg[0])
         sum = {1'b0, ph_reg} + {1'b0, a_reg};
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               a_next  = mcnd;
               ph_next = '0;
               pl_next = mplr;
               n_next  = CBIT'(W);
            end
         end
         ST_OP: begin
            {ph_next, pl_next} = {sum, pl_reg[W-1:1]};
            n_next = n_reg - CBIT'(1);
         end
         default: ;
      endcase
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (start) state_next = ST_OP;
         ST_OP:   if (n_next == '0) state_next = ST_DONE;
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Outputs forced to their idle values while reset is asserted.
   always_comb begin
      ready     = (state_reg == ST_IDLE) || !reset_n;
      done_tick = (state_reg == ST_DONE) && reset_n;
      prod      = reset_n ? {ph_reg, pl_reg} : '0;
   end

endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult (W=8).
// Directed vector table, multi-cycle corner sequences, random sweep.
module tb_seq_mult;

   localparam int W = 8;

   logic           clk = 1'b0;
   logic           reset_n;
   logic           start;
   logic [W-1:0]   mcnd;
   logic [W-1:0]   mplr;
   logic           ready;
   logic           done_tick;
   logic [2*W-1:0] prod;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [2*W-1:0] p;
   } vec_t;

   vec_t vecs [7];

   seq_mult #(.W(W)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .mcnd      (mcnd),
      .mplr      (mplr),
      .ready     (ready),
      .done_tick (done_tick),
      .prod      (prod)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h",
                  name, act, exp);
      end
   endtask

   task automatic run_op(input  logic [W-1:0]   a,
                         input  logic [W-1:0]   b,
                         output logic [2*W-1:0] p,
                         output int             lat,
                         output bit             rdy_after);
      @(negedge clk);
      mcnd  = a;
      mplr  = b;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      mcnd  = 8'($urandom);
      mplr  = 8'($urandom);
      lat   = -1;
      p     = '0;
      for (int c = 1; c <= 3 * W; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (done_tick) begin
            lat = c;
            p   = prod;
            break;
         end
      end
      @(posedge clk);
      @(negedge clk);
      rdy_after = ready && !done_tick;
   endtask

   initial begin
      logic [2*W-1:0] p, p1, p2, last;
      int lat, ndone, t1, t2;
      bit rdy;

      vecs[0] = '{8'd13,  8'd11,  16'h008F};
      vecs[1] = '{8'd255, 8'd255, 16'hFE01};
      vecs[2] = '{8'd0,   8'd200, 16'h0000};
      vecs[3] = '{8'd200, 8'd0,   16'h0000};
      vecs[4] = '{8'd1,   8'd255, 16'h00FF};
      vecs[5] = '{8'd128, 8'd2,   16'h0100};
      vecs[6] = '{8'd6,   8'd9,   16'd54};

      reset_n = 1'b0;
      start   = 1'b0;
      mcnd    = '0;
      mplr    = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_prod", 32'(prod), 32'd0);
      chk("rst_done", 32'(done_tick), 32'd0);
      reset_n = 1'b1;

      for (int i = 0; i < 4; i++) begin
         mcnd = 8'($urandom);
         mplr = 8'($urandom);
         @(posedge clk);
         @(negedge clk);
         chk("idle_ready", 32'(ready), 32'd1);
         chk("idle_prod", 32'(prod), 32'd0);
         chk("idle_done", 32'(done_tick), 32'd0);
      end

      last = '0;
      for (int i = 0; i < 7; i++) begin
         run_op(vecs[i].a, vecs[i].b, p, lat, rdy);
         chk($sformatf("vec%0d_prod", i), 32'(p), 32'(vecs[i].p));
         chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(W));
         chk($sformatf("vec%0d_rdy", i), 32'(rdy), 32'd1);
         last = vecs[i].p;
      end

      for (int i = 0; i < 3; i++) begin
         mcnd = 8'($urandom);
         mplr = 8'($urandom);
         @(posedge clk);
         @(negedge clk);
         chk("hold_prod", 32'(prod), 32'(last));
      end

      // Second start during op must be ignored.
      @(negedge clk);
      mcnd  = 8'd13;
      mplr  = 8'd11;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      ndone = 0;
      lat   = -1;
      p     = '0;
      for (int c = 1; c <= 3 * W; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (c == 3) begin
            start = 1'b1;
            mcnd  = 8'd7;
            mplr  = 8'd7;
         end else if (c == 4) begin
            start = 1'b0;
         end
         if (done_tick) begin
            ndone++;
            if (lat < 0) begin
               lat = c;
               p   = prod;
            end
         end
      end
      chk("busy_ndone", 32'(ndone), 32'd1);
      chk("busy_lat", 32'(lat), 32'(W));
      chk("busy_prod", 32'(p), 32'd143);
      chk("busy_hold", 32'(prod), 32'd143);

      // Reset during the 4th op cycle aborts.
      @(negedge clk);
      mcnd  = 8'd50;
      mplr  = 8'd3;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("abort_low_ready", 32'(ready), 32'd1);
      chk("abort_low_prod", 32'(prod), 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      chk("abort_ready", 32'(ready), 32'd1);
      chk("abort_prod", 32'(prod), 32'd0);
      chk("abort_done", 32'(done_tick), 32'd0);
      ndone = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (done_tick) ndone++;
      end
      chk("abort_ndone", 32'(ndone), 32'd0);
      chk("abort_prod_idle", 32'(prod), 32'd0);
      run_op(8'd6, 8'd9, p, lat, rdy);
      chk("post_abort_prod", 32'(p), 32'd54);
      chk("post_abort_lat", 32'(lat), 32'(W));

      // start held high: two ops, W+2 apart.
      @(negedge clk);
      mcnd  = 8'd3;
      mplr  = 8'd5;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      mcnd  = 8'd10;
      mplr  = 8'd10;
      t1    = -1;
      t2    = -1;
      p1    = '0;
      p2    = '0;
      ndone = 0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (done_tick) begin
            ndone++;
            if (t1 < 0) begin
               t1 = c;
               p1 = prod;
            end else if (t2 < 0) begin
               t2 = c;
               p2 = prod;
               start = 1'b0;
            end
         end
      end
      start = 1'b0;
      chk("b2b_ndone", 32'(ndone), 32'd2);
      chk("b2b_t1", 32'(t1), 32'(W));
      chk("b2b_gap", 32'(t2 - t1), 32'(W + 2));
      chk("b2b_p1", 32'(p1), 32'd15);
      chk("b2b_p2", 32'(p2), 32'd100);

      for (int i = 0; i < 1000; i++) begin
         logic [W-1:0] a, b;
         logic [2*W-1:0] exp;
         a   = 8'($urandom);
         b   = 8'($urandom);
         exp = {8'd0, a} * {8'd0, b};
         run_op(a, b, p, lat, rdy);
         chk("rand_prod", 32'(p), 32'(exp));
         chk("rand_lat", 32'(lat), 32'(W));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
